axi_read_arbiter_n_to_1: RTL and testbench

// - Parametrised N-to-1 AXI4 read-only interconnect. Merges the read traffic of N workgroup masters onto one memory-side master port.
// - Round-robin AR arbitration with a registered AR slice.
// - Master index is prefixed onto the outgoing ARID; R beats are routed back by that prefix.
// - Per-port outstanding-burst limit; sticky error on unroutable R beats.

---
 rtl/axi_read_arbiter_n_to_1_pkg.sv | 34 +++
 rtl/axi_read_arbiter_n_to_1_if.sv | 35 +++
 rtl/axi_read_arbiter_n_to_1_rr.sv | 50 +++++
 rtl/axi_read_arbiter_n_to_1.sv | 145 ++++++++++++++
 tb/tb_axi_read_arbiter_n_to_1.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_read_arbiter_n_to_1_pkg.sv
// rtl/axi_read_arbiter_n_to_1_pkg.sv - shared types and default widths for the AXI read arbiter
// No ports. Provides:
//   - default parameter values
//   - ar_beat_t, the AR slice payload, sized for the widest supported address and ID
//   - AXI_BURST_INCR
//   - slice_state_t, the AR slice state encoding
package axi_rd_pkg;

   localparam int DEF_N_PORTS = 4;
   localparam int DEF_ADDR_W  = 64;
   localparam int DEF_DATA_W  = 512;
   localparam int DEF_ID_W    = 7;
   localparam int DEF_MAX_OUT = 8;

   // Slice payload is stored at maximum width; the top truncates on output.
   localparam int AR_ADDR_W_MAX = 64;
   localparam int AR_ID_W_MAX   = 32;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef struct packed {
      logic [AR_ADDR_W_MAX-1:0] addr;
      logic [AR_ID_W_MAX-1:0]   id;
      logic [7:0]               len;
      logic [2:0]               size;
      logic [1:0]               burst;
   } ar_beat_t;

   typedef enum logic {
      SLICE_EMPTY = 1'b0,
      SLICE_FULL  = 1'b1
   } slice_state_t;

endpackage

// File: rtl/axi_read_arbiter_n_to_1_if.sv
// rtl/axi_read_arbiter_n_to_1_if.sv - AXI4 read channel bundle for NP lanes
// Lane k of the packed AR fields sits at [k*W +: W].
// The R data, ID, response and last fields are shared by all lanes and qualified by rvalid[k].
//   master modport : drives ar*, rready; samples arready, r*
//   slave modport  : drives arready, r*; samples ar*, rready
interface axi_read_arbiter_n_to_1_if #(
   parameter int NP     = 1,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int ID_W   = 7
);
   logic [NP-1:0]        arvalid;
   logic [NP-1:0]        arready;
   logic [NP*ADDR_W-1:0] araddr;
   logic [NP*ID_W-1:0]   arid;
   logic [NP*8-1:0]      arlen;
   logic [NP*3-1:0]      arsize;
   logic [NP*2-1:0]      arburst;
   logic [NP-1:0]        rvalid;
   logic [NP-1:0]        rready;
   logic [DATA_W-1:0]    rdata;
   logic [ID_W-1:0]      rid;
   logic [1:0]           rresp;
   logic                 rlast;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rid, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rid, rresp, rlast
   );
endinterface

// File: rtl/axi_read_arbiter_n_to_1_rr.sv
// rtl/axi_read_arbiter_n_to_1_rr.sv - round-robin arbiter with one-hot grant
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : per-requester request
//   en         : the grant may be issued this cycle
//   gnt        : one-hot grant, all zero when en=0
//   gnt_idx    : index of the selected requester
// The pointer advances past the winner only when a grant is actually issued.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);
   // One spare bit so ptr+i can be folded back below N without overflow.
   localparam int CW = PW + 1;

   logic [PW-1:0] ptr_q;
   logic          found;
   logic [CW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + CW'(i);
         if (cand >= CW'(N)) cand = cand - CW'(N);
         if (!found && req[cand[PW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[PW-1:0];
         end
      end
      if (en && found) gnt[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (en && found) begin
         ptr_q <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end
endmodule

// File: rtl/axi_read_arbiter_n_to_1.sv
// rtl/axi_read_arbiter_n_to_1.sv - N-to-1 AXI4 read interconnect with round-robin AR arbitration
// Ports:
//   aclk, aresetn : clock and asynchronous active-low reset
//   s             : N_PORTS-lane slave side facing the workgroup masters
//   m             : single-lane master side toward memory
//                   arid = {port index, s_arid}
//   rd_err        : sticky flag, set by an R beat whose prefix has no port
//   outstanding   : packed per-port outstanding burst counts
module axi_read_arbiter_n_to_1
   import axi_rd_pkg::*;
#(
   parameter  int N_PORTS = DEF_N_PORTS,
   parameter  int ADDR_W  = DEF_ADDR_W,
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int ID_W    = DEF_ID_W,
   parameter  int MAX_OUT = DEF_MAX_OUT,
   localparam int IDX_W   = $clog2(N_PORTS),
   localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   axi_read_arbiter_n_to_1_if.slave  s,
   axi_read_arbiter_n_to_1_if.master m,
   output logic                     rd_err,
   output logic [N_PORTS*CNT_W-1:0] outstanding
);
   slice_state_t       state_q, state_d;
   ar_beat_t           slice_q, beat_in;
   logic [N_PORTS-1:0] eligible, gnt, dec;
   logic [IDX_W-1:0]   gnt_idx, r_idx;
   logic               gnt_any, slice_accept, r_routable, r_hs_last;
   logic [CNT_W-1:0]   cnt_q [N_PORTS];
   logic               unused_slice;

   // Arbitration: eligibility excludes ports at their outstanding limit.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < N_PORTS; k++)
         eligible[k] = s.arvalid[k] && (32'(cnt_q[k]) < 32'(MAX_OUT));
   end

   // Accepting while FULL relies on m_arready draining the slice in the same cycle.
   // The reset term keeps s_arready low while aresetn is asserted.
   assign slice_accept = aresetn && ((state_q == SLICE_EMPTY) || m.arready[0]);

   rr_arbiter #(.N(N_PORTS)) u_rr (
      .clk     (aclk),
      .rst_n   (aresetn),
      .req     (eligible),
      .en      (slice_accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign gnt_any   = |gnt;
   assign s.arready = gnt;

   // AR slice
   always_comb begin
      beat_in       = '0;
      beat_in.addr  = AR_ADDR_W_MAX'(s.araddr[gnt_idx*ADDR_W +: ADDR_W]);
      beat_in.id    = AR_ID_W_MAX'({gnt_idx, s.arid[gnt_idx*ID_W +: ID_W]});
      beat_in.len   = s.arlen[gnt_idx*8 +: 8];
      beat_in.size  = s.arsize[gnt_idx*3 +: 3];
      beat_in.burst = s.arburst[gnt_idx*2 +: 2];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SLICE_EMPTY: if (gnt_any) state_d = SLICE_FULL;
         SLICE_FULL:  if (m.arready[0] && !gnt_any) state_d = SLICE_EMPTY;
         default:     state_d = SLICE_EMPTY;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= SLICE_EMPTY;
         slice_q <= '0;
      end else begin
         state_q <= state_d;
         if (gnt_any) slice_q <= beat_in;
      end
   end

   assign m.arvalid  = (state_q == SLICE_FULL);
   assign m.araddr   = slice_q.addr[ADDR_W-1:0];
   assign m.arid     = slice_q.id[ID_W+IDX_W-1:0];
   assign m.arlen    = slice_q.len;
   assign m.arsize   = slice_q.size;
   assign m.arburst  = slice_q.burst;
   assign unused_slice = ^{slice_q.addr, slice_q.id};

   // R routing on the ID prefix
   assign r_idx      = m.rid[ID_W+IDX_W-1:ID_W];
   assign r_routable = (32'(r_idx) < 32'(N_PORTS));

   always_comb begin
      s.rvalid  = '0;
      m.rready  = 1'b1;
      if (r_routable) begin
         s.rvalid[r_idx] = m.rvalid[0];
         m.rready        = s.rready[r_idx];
      end
   end

   assign s.rdata   = m.rdata;
   assign s.rid     = m.rid[ID_W-1:0];
   assign s.rresp   = m.rresp;
   assign s.rlast   = m.rlast;
   assign r_hs_last = m.rvalid[0] && m.rready[0] && m.rlast;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                      rd_err <= 1'b0;
      else if (m.rvalid[0] && !r_routable) rd_err <= 1'b1;
   end

   // Outstanding burst counters
   always_comb begin
      dec = '0;
      for (int k = 0; k < N_PORTS; k++)
         dec[k] = r_hs_last && r_routable && (r_idx == IDX_W'(k));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < N_PORTS; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_PORTS; k++) begin
            assert (!(dec[k] && !gnt[k] && (cnt_q[k] == '0)));
            case ({gnt[k], dec[k]})
               2'b10:   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
               2'b01:   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
               default: cnt_q[k] <= cnt_q[k];
            endcase
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int k = 0; k < N_PORTS; k++) outstanding[k*CNT_W +: CNT_W] = cnt_q[k];
   end
endmodule

// File: tb/tb_axi_read_arbiter_n_to_1.sv
// tb/tb_axi_read_arbiter_n_to_1.sv - directed self-checking bench for axi_read_arbiter_n_to_1
module tb_axi_read_arbiter_n_to_1;
   import axi_rd_pkg::*;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int IW = 7;
   localparam int NA = 4;
   localparam int NB = 3;
   localparam int XW = 2;
   localparam int CW = 4;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   axi_read_arbiter_n_to_1_if #(.NP(NA), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW))      sa();
   axi_read_arbiter_n_to_1_if #(.NP(1),  .ADDR_W(AW), .DATA_W(DW), .ID_W(IW + XW)) ma();
   axi_read_arbiter_n_to_1_if #(.NP(NB), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW))      sb();
   axi_read_arbiter_n_to_1_if #(.NP(1),  .ADDR_W(AW), .DATA_W(DW), .ID_W(IW + XW)) mb();

   logic              rd_err_a, rd_err_b;
   logic [NA*CW-1:0]  out_a;
   logic [NB*CW-1:0]  out_b;

   axi_read_arbiter_n_to_1 #(.N_PORTS(NA), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(8)) dut_a (
      .aclk(aclk), .aresetn(aresetn), .s(sa), .m(ma), .rd_err(rd_err_a), .outstanding(out_a));
   axi_read_arbiter_n_to_1 #(.N_PORTS(NB), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(8)) dut_b (
      .aclk(aclk), .aresetn(aresetn), .s(sb), .m(mb), .rd_err(rd_err_b), .outstanding(out_b));

   int total = 0;
   int bad   = 0;

   function automatic logic [CW-1:0] cnt_a(int k);
      return out_a[k*CW +: CW];
   endfunction

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic smp();
      @(negedge aclk);
   endtask

   task automatic idle();
      sa.arvalid = '0; sa.araddr = '0; sa.arid = '0; sa.arlen = '0; sa.arsize = '0; sa.arburst = '0; sa.rready = '0;
      sb.arvalid = '0; sb.araddr = '0; sb.arid = '0; sb.arlen = '0; sb.arsize = '0; sb.arburst = '0; sb.rready = '0;
      ma.arready = '0; ma.rvalid = '0; ma.rdata = '0; ma.rid = '0; ma.rresp = '0; ma.rlast = 1'b0;
      mb.arready = '0; mb.rvalid = '0; mb.rdata = '0; mb.rid = '0; mb.rresp = '0; mb.rlast = 1'b0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      idle();
      cyc();
      cyc();
      aresetn = 1'b1;
   endtask

   task automatic set_port(int k, logic [AW-1:0] addr, logic [IW-1:0] id, logic [7:0] len);
      sa.araddr[k*AW +: AW] = addr;
      sa.arid[k*IW +: IW]   = id;
      sa.arlen[k*8 +: 8]    = len;
      sa.arsize[k*3 +: 3]   = 3'd6;
      sa.arburst[k*2 +: 2]  = AXI_BURST_INCR;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      idle();
      sa.arvalid = 4'hF;
      sb.arvalid = 3'h7;
      ma.arready = 1'b1;
      smp();
      total++; if (sa.arready !== 4'b0000) begin bad++; $display("FAIL reset_s_arready: got %b want 0000", sa.arready); end
      total++; if (ma.arvalid !== 1'b0) begin bad++; $display("FAIL reset_m_arvalid: got %b want 0", ma.arvalid); end
      total++; if (rd_err_a !== 1'b0 || rd_err_b !== 1'b0) begin bad++; $display("FAIL reset_rd_err: got %b%b want 00", rd_err_a, rd_err_b); end
      total++; if (out_a !== '0 || out_b !== '0) begin bad++; $display("FAIL reset_outstanding: got %h/%h want 0/0", out_a, out_b); end
      cyc();
      aresetn = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_port(0, 64'h1000, 7'd5, 8'd3);
      sa.arvalid = 4'b0001;
      smp();
      total++; if (sa.arready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", sa.arready); end
      total++; if (ma.arvalid !== 1'b0) begin bad++; $display("FAIL single_no_early_arvalid: got %b want 0", ma.arvalid); end
      cyc();
      sa.arvalid = '0;
      smp();
      total++; if (ma.arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %b want 1", ma.arvalid); end
      total++; if (ma.arid !== 9'h005) begin bad++; $display("FAIL single_arid: got %h want 005", ma.arid); end
      total++; if (ma.araddr !== 64'h1000 || ma.arlen !== 8'd3) begin bad++; $display("FAIL single_addr_len: got %h/%0d want 1000/3", ma.araddr, ma.arlen); end
      total++; if (cnt_a(0) !== 4'd1) begin bad++; $display("FAIL single_out_inc: got %0d want 1", cnt_a(0)); end
      ma.arready = 1'b1;
      cyc();
      ma.arready = 1'b0;
      smp();
      total++; if (ma.arvalid !== 1'b0) begin bad++; $display("FAIL single_slice_drain: got %b want 0", ma.arvalid); end
      for (int b = 0; b < 4; b++) begin
         ma.rvalid = 1'b1;
         ma.rid    = 9'h005;
         ma.rdata  = 64'hA0 + 64'(b);
         ma.rlast  = (b == 3);
         sa.rready = 4'b0001;
         smp();
         total++;
         if (sa.rvalid !== 4'b0001 || sa.rid !== 7'd5 || sa.rdata !== 64'hA0 + 64'(b) || ma.rready !== 1'b1) begin
            bad++;
            $display("FAIL single_rbeat%0d: got rvalid=%b rid=%0d rdata=%h rready=%b want 0001/5/%h/1", b, sa.rvalid, sa.rid, sa.rdata, ma.rready, 64'hA0 + 64'(b));
         end
         cyc();
      end
      ma.rvalid = 1'b0;
      ma.rlast  = 1'b0;
      sa.rready = '0;
      smp();
      total++; if (cnt_a(0) !== 4'd0) begin bad++; $display("FAIL single_out_dec: got %0d want 0", cnt_a(0)); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      logic [1:0] exp_pfx;
      do_reset();
      for (int k = 0; k < NA; k++) set_port(k, 64'(k + 1) << 12, 7'(16 + k), 8'd0);
      sa.arvalid = 4'hF;
      ma.arready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_gnt = 4'b0001 << (i % 4);
         exp_pfx = 2'((i + 3) % 4);
         smp();
         total++; if (sa.arready !== exp_gnt) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, sa.arready, exp_gnt); end
         if (i > 0) begin
            total++;
            if (ma.arvalid !== 1'b1 || ma.arid[8:7] !== exp_pfx) begin
               bad++; $display("FAIL rr_stream%0d: got arvalid=%b pfx=%0d want 1/%0d", i, ma.arvalid, ma.arid[8:7], exp_pfx);
            end
         end
         cyc();
      end
      sa.arvalid = '0;
      smp();
      total++; if (out_a !== 16'h2222) begin bad++; $display("FAIL rr_outstanding: got %h want 2222", out_a); end
   endtask

   task automatic test_stall();
      do_reset();
      set_port(0, 64'hA000, 7'h11, 8'd1);
      set_port(3, 64'hD000, 7'h33, 8'd2);
      sa.arvalid = 4'b1001;
      smp();
      total++; if (sa.arready !== 4'b0001) begin bad++; $display("FAIL stall_first_grant: got %b want 0001", sa.arready); end
      cyc();
      for (int i = 0; i < 10; i++) begin
         smp();
         total++;
         if (sa.arready !== 4'b0000 || ma.arvalid !== 1'b1 || ma.arid !== 9'h011 || ma.araddr !== 64'hA000) begin
            bad++; $display("FAIL stall_hold%0d: got arready=%b arvalid=%b arid=%h araddr=%h want 0000/1/011/a000", i, sa.arready, ma.arvalid, ma.arid, ma.araddr);
         end
         cyc();
      end
      ma.arready = 1'b1;
      smp();
      total++; if (sa.arready !== 4'b1000) begin bad++; $display("FAIL stall_release_grant: got %b want 1000", sa.arready); end
      cyc();
      sa.arvalid = '0;
      smp();
      total++; if (ma.arvalid !== 1'b1 || ma.arid !== {2'd3, 7'h33}) begin bad++; $display("FAIL stall_next_beat: got %b/%h want 1/%h", ma.arvalid, ma.arid, {2'd3, 7'h33}); end
      cyc();
      ma.arready = 1'b0;
   endtask

   task automatic test_limit();
      do_reset();
      set_port(1, 64'h2000, 7'h01, 8'd0);
      set_port(2, 64'h3000, 7'h22, 8'd0);
      ma.arready = 1'b1;
      sa.arvalid = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         smp();
         total++; if (sa.arready !== 4'b0100) begin bad++; $display("FAIL limit_fill%0d: got %b want 0100", i, sa.arready); end
         cyc();
      end
      sa.arvalid = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         smp();
         total++;
         if (sa.arready !== 4'b0010 || cnt_a(2) !== 4'd8) begin
            bad++; $display("FAIL limit_block%0d: got arready=%b out2=%0d want 0010/8", i, sa.arready, cnt_a(2));
         end
         cyc();
      end
      sa.arvalid = 4'b0100;
      ma.rvalid  = 1'b1;
      ma.rid     = {2'd2, 7'h22};
      ma.rlast   = 1'b1;
      sa.rready  = 4'b0100;
      smp();
      total++;
      if (sa.arready !== 4'b0000 || ma.rready !== 1'b1 || sa.rvalid !== 4'b0100) begin
         bad++; $display("FAIL limit_rlast_cycle: got arready=%b rready=%b rvalid=%b want 0000/1/0100", sa.arready, ma.rready, sa.rvalid);
      end
      cyc();
      ma.rvalid = 1'b0;
      ma.rlast  = 1'b0;
      sa.rready = '0;
      smp();
      total++;
      if (cnt_a(2) !== 4'd7 || sa.arready !== 4'b0100) begin
         bad++; $display("FAIL limit_regrant: got out2=%0d arready=%b want 7/0100", cnt_a(2), sa.arready);
      end
      cyc();
      sa.arvalid = '0;
      smp();
      total++; if (cnt_a(2) !== 4'd8) begin bad++; $display("FAIL limit_refill: got %0d want 8", cnt_a(2)); end
   endtask

   task automatic test_unroutable();
      do_reset();
      mb.rvalid = 1'b1;
      mb.rid    = {2'd3, 7'h01};
      mb.rlast  = 1'b1;
      sb.rready = 3'b000;
      smp();
      total++; if (mb.rready !== 1'b1 || sb.rvalid !== 3'b000) begin bad++; $display("FAIL unroute_drop: got rready=%b rvalid=%b want 1/000", mb.rready, sb.rvalid); end
      total++; if (rd_err_b !== 1'b0) begin bad++; $display("FAIL unroute_err_early: got %b want 0", rd_err_b); end
      cyc();
      mb.rvalid = 1'b0;
      mb.rlast  = 1'b0;
      smp();
      total++; if (rd_err_b !== 1'b1) begin bad++; $display("FAIL unroute_err_set: got %b want 1", rd_err_b); end
      mb.rvalid = 1'b1;
      mb.rid    = {2'd2, 7'h01};
      smp();
      total++; if (sb.rvalid !== 3'b100 || mb.rready !== 1'b0) begin bad++; $display("FAIL route_port2: got rvalid=%b rready=%b want 100/0", sb.rvalid, mb.rready); end
      cyc();
      mb.rvalid = 1'b0;
      cyc();
      cyc();
      smp();
      total++; if (rd_err_b !== 1'b1 || rd_err_a !== 1'b0) begin bad++; $display("FAIL unroute_err_sticky: got b=%b a=%b want 1/0", rd_err_b, rd_err_a); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_port(0, 64'h4000, 7'h04, 8'd7);
      sa.arvalid = 4'b0001;
      mb.rvalid  = 1'b1;
      mb.rid     = {2'd3, 7'h00};
      cyc();
      sa.arvalid = '0;
      mb.rvalid  = 1'b0;
      smp();
      total++;
      if (ma.arvalid !== 1'b1 || cnt_a(0) !== 4'd1 || rd_err_b !== 1'b1) begin
         bad++; $display("FAIL areset_pre: got arvalid=%b out0=%0d err=%b want 1/1/1", ma.arvalid, cnt_a(0), rd_err_b);
      end
      sa.arvalid = 4'b0010;
      ma.arready = 1'b1;
      #1;
      total++; if (sa.arready !== 4'b0010) begin bad++; $display("FAIL areset_pre_grant: got %b want 0010", sa.arready); end
      #1;
      aresetn = 1'b0;
      #1;
      total++;
      if (ma.arvalid !== 1'b0 || sa.arready !== 4'b0000 || out_a !== '0 || rd_err_b !== 1'b0) begin
         bad++; $display("FAIL areset_immediate: got arvalid=%b arready=%b out=%h err=%b want 0/0000/0/0", ma.arvalid, sa.arready, out_a, rd_err_b);
      end
      idle();
      cyc();
      aresetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_limit();
      test_unroutable();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
